jesd204_rx_fec_header_extract: RTL and testbench
================================================

# jesd204_rx_fec_header_extract

Receive-side sync-header processor for JESD204C 64b/66b links running in FEC mode. It consumes one 64-bit block plus its 2-bit sync header per valid cycle. It locates and locks to the multiblock boundary using the end-of-multiblock marker, and extracts the 26-bit FEC parity carried in the sync-header stream. It presents block-aligned data, `eomb` and `fec_in`/`fec_in_valid` to `jesd204_fec_decode` with the timing that block expects.

## Interface
Parameters:
- `DATA_WIDTH`, 64, block payload width; only 64 is supported.
- `LOCK_MB`, 4, number of consecutive good markers (including the first match) required to enter LOCKED; range 1..15.
- `UNLOCK_MB`, 2, number of consecutive bad markers in LOCKED that return the block to HUNT; range 1..15.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, reset, synchronous, active-high.
- `in_valid`, in, 1, one block per asserted cycle.
- `in_header`, in, 2, sync header: 2'b01 is bit 1, 2'b10 is bit 0, 2'b00 and 2'b11 are invalid.
- `in_data`, in, DATA_WIDTH, block payload.
- `out_valid`, out, 1, registered copy of `in_valid`.
- `out_data`, out, DATA_WIDTH, registered copy of `in_data`.
- `out_eomb`, out, 1, high with block 31 of a multiblock; LOCKED only.
- `fec_out`, out, 26, last extracted FEC word.
- `fec_out_valid`, out, 1, one-cycle pulse that qualifies `fec_out`.
- `locked`, out, 1, high while state is LOCKED.
- `header_err`, out, 1, one-cycle pulse when an invalid header is received.
- `marker_err`, out, 1, one-cycle pulse when a marker check fails in CHECK or LOCKED.

## Operation
- Sync-header bit: `sh = (in_header == 2'b01)`. An invalid header counts as `sh = 0` and pulses `header_err`.
- Every valid cycle, `sh` shifts into a 6-bit history `hist` (newest bit in the LSb).
- Multiblock format, header bits in block order 0..31:
  - blocks 0..25 carry FEC[25:0], MSb first; this is the parity of the previous multiblock.
  - block 26 is 1.
  - blocks 27..31 are 00001.
  - A marker match is `hist == 6'b100001` after block 31 is shifted in.
- Block counter `blk` is 5 bits and advances only on `in_valid`. It wraps 31 -> 0.
- State machine:
  - HUNT: on each valid cycle, if `hist` (including the current bit) matches, set `blk` so that the next block is index 0, set `good_cnt = 1`, and go to CHECK. If `LOCK_MB == 1`, go directly to LOCKED instead.
  - CHECK: at `blk == 31`, a match increments `good_cnt`; when `good_cnt` reaches LOCK_MB, go to LOCKED. A mismatch pulses `marker_err` and returns to HUNT.
  - LOCKED: at `blk == 31`, a match clears `bad_cnt`. A mismatch pulses `marker_err` and increments `bad_cnt`; when `bad_cnt` reaches UNLOCK_MB, go to HUNT and clear `bad_cnt`.
- FEC capture:
  - For blocks 0..25, `fec_sr <= {fec_sr[24:0], sh}`.
  - At block 25, `fec_out` is loaded with the completed word.
  - `fec_out` holds its value until the next load.
- `fec_out_valid` pulses in the output cycle that carries block 26, only when the state is LOCKED at that cycle.
- `out_eomb` asserts with output block 31 only when the state is LOCKED at that cycle. An exit from LOCKED at block 31 suppresses that `out_eomb`.
- Data is never modified or dropped. It is passed through in every state.

## Timing
- Data path latency is 1 cycle: `out_data`/`out_valid` at t+1 equal `in_data`/`in_valid` at t.
- For a contiguous stream, `out_eomb` on block 31 and `fec_out_valid` on block 26 of the next multiblock are 27 cycles apart. This matches the decoder's `fec_in_valid` expectation.
- State and counters update on the same edge that registers the corresponding block. `locked` therefore rises with output block 31 of the LOCK_MB-th matching multiblock.
- Simultaneous events:
  - An invalid header at a marker position produces both `header_err` and `marker_err` in the same cycle.
  - A mismatch that causes unlock suppresses that `fec_out_valid`/`out_eomb`.
- Reset values:
  - All outputs are 0, including `fec_out`.
  - State is HUNT; `blk`, `good_cnt`, `bad_cnt`, `hist` and `fec_sr` are 0.
- Reset asserted mid-stream clears everything on the next edge. Outputs are 0 in the cycle after the reset edge, and hunting restarts after `rst` falls.
- Gaps in `in_valid` stall all counters and shift registers. Output pulses occur only when `out_valid` is high.

## Structure
- `jesd204_fec_pkg` holds:
  - `FEC_WIDTH = 26`, `MB_BLOCKS = 32`, `EOMB_MARKER = 6'b100001`.
  - `SH_ONE = 2'b01`, `SH_ZERO = 2'b10`.
  - The `fec_sh_state_t` enum {HUNT, CHECK, LOCKED}.
- Sub-module `jesd204_fec_sh_lock` contains the state machine, `blk`, `good_cnt` and `bad_cnt`. It outputs `blk`, `state` and `marker_err`.
- The top level holds the data and FEC registers.

## Test plan
- Encoder output framed with correct headers, contiguous, default params -> `locked` rises at the end of the 4th multiblock. From then on, `fec_out` equals the encoder FEC of the previous multiblock, `fec_out_valid` follows `out_eomb` by 27 cycles, and `jesd204_fec_decode` reports no errors.
- FEC bits that mimic 100001 before the true marker -> the block enters CHECK, fails on the next check with one `marker_err`, re-hunts, and locks on the true boundary.
- In LOCKED, one corrupted marker -> one `marker_err`, `locked` stays 1. Two consecutive corrupted markers -> `locked` falls at output block 31 of the second bad multiblock, and no `out_eomb` is produced on that block.
- `in_header = 2'b11` at block 5 -> `header_err` pulses, FEC bit 20 reads 0, and the decoder sees a 1-bit FEC error.
- `in_valid` low for 3 cycles mid-multiblock -> `blk` and `fec_out` are unaffected, and the output pulses are delayed by exactly 3 cycles.
- `rst` pulsed while LOCKED -> all outputs are 0 in the next cycle, and the block relocks after 4 markers.

Source files
------------

// File: rtl/jesd204_fec_pkg.sv
// Shared constants and state type for the JESD204C FEC-mode sync-header receive path.
// Holds the multiblock geometry, sync-header codes and lock FSM states.
package jesd204_fec_pkg;

   localparam int FEC_WIDTH = 26;
   localparam int MB_BLOCKS = 32;

   localparam logic [5:0] EOMB_MARKER = 6'b100001;

   localparam logic [1:0] SH_ONE  = 2'b01;
   localparam logic [1:0] SH_ZERO = 2'b10;

   localparam logic [4:0] LAST_BLK      = 5'(MB_BLOCKS - 1);
   localparam logic [4:0] FEC_LAST_BLK  = 5'(FEC_WIDTH - 1);
   localparam logic [4:0] FEC_VALID_BLK = 5'(FEC_WIDTH);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } fec_sh_state_t;

endpackage

// File: rtl/jesd204_fec_sh_lock.sv
// Multiblock lock state machine: hunts for the end-of-multiblock marker, confirms it
// LOCK_MB times, and drops lock after UNLOCK_MB consecutive bad markers.
module jesd204_fec_sh_lock
   import jesd204_fec_pkg::*;
#(
   parameter int LOCK_MB   = 4,
   parameter int UNLOCK_MB = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          marker_match,
   output logic [4:0]    blk,
   output fec_sh_state_t state,
   output fec_sh_state_t state_next,
   output logic          marker_err
);

   localparam logic [3:0] LOCK_N   = 4'(LOCK_MB);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_MB);

   logic [3:0] good_cnt;
   logic [3:0] bad_cnt;
   logic       at_marker;

   assign at_marker = (blk == LAST_BLK);

   always_comb begin
      state_next = state;
      if (in_valid) begin
         case (state)
            HUNT: begin
               if (marker_match) state_next = (LOCK_N == 4'd1) ? LOCKED : CHECK;
            end
            CHECK: begin
               if (at_marker) begin
                  if (!marker_match)                    state_next = HUNT;
                  else if (good_cnt + 4'd1 >= LOCK_N)   state_next = LOCKED;
               end
            end
            LOCKED: begin
               if (at_marker && !marker_match && (bad_cnt + 4'd1 >= UNLOCK_N)) state_next = HUNT;
            end
            default: state_next = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         blk        <= 5'd0;
         good_cnt   <= 4'd0;
         bad_cnt    <= 4'd0;
         marker_err <= 1'b0;
      end else begin
         marker_err <= 1'b0;
         state      <= state_next;
         if (in_valid) begin
            blk <= blk + 5'd1;
            case (state)
               HUNT: begin
                  // The matching block is block 31, so the following block is index 0.
                  if (marker_match) begin
                     blk      <= 5'd0;
                     good_cnt <= 4'd1;
                     bad_cnt  <= 4'd0;
                  end
               end
               CHECK: begin
                  if (at_marker) begin
                     if (marker_match) good_cnt   <= good_cnt + 4'd1;
                     else              marker_err <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (at_marker) begin
                     if (marker_match) begin
                        bad_cnt <= 4'd0;
                     end else begin
                        marker_err <= 1'b1;
                        bad_cnt    <= (bad_cnt + 4'd1 >= UNLOCK_N) ? 4'd0 : bad_cnt + 4'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/jesd204_rx_fec_header_extract.sv
// Receive sync-header processor for JESD204C FEC mode: passes data through with one cycle
// of latency, tracks multiblock alignment and extracts the 26-bit FEC word per multiblock.
module jesd204_rx_fec_header_extract
   import jesd204_fec_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int LOCK_MB    = 4,
   parameter int UNLOCK_MB  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [1:0]            in_header,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_eomb,
   output logic [25:0]           fec_out,
   output logic                  fec_out_valid,
   output logic                  locked,
   output logic                  header_err,
   output logic                  marker_err
);

   logic                 sh;
   logic                 hdr_bad;
   logic [5:0]           hist;
   logic [5:0]           hist_next;
   logic                 marker_match;
   // Only the 25 earlier bits are stored; the 26th arrives as the current sh.
   logic [FEC_WIDTH-2:0] fec_sr;
   logic [4:0]           blk;
   fec_sh_state_t        state;
   fec_sh_state_t        state_next;

   assign sh           = (in_header == SH_ONE);
   assign hdr_bad      = (in_header != SH_ONE) && (in_header != SH_ZERO);
   assign hist_next    = {hist[4:0], sh};
   assign marker_match = (hist_next == EOMB_MARKER);
   assign locked       = (state == LOCKED);

   jesd204_fec_sh_lock #(
      .LOCK_MB   (LOCK_MB),
      .UNLOCK_MB (UNLOCK_MB)
   ) u_lock (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .marker_match (marker_match),
      .blk          (blk),
      .state        (state),
      .state_next   (state_next),
      .marker_err   (marker_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_eomb      <= 1'b0;
         fec_out       <= '0;
         fec_out_valid <= 1'b0;
         header_err    <= 1'b0;
         hist          <= '0;
         fec_sr        <= '0;
      end else begin
         out_valid     <= in_valid;
         out_data      <= in_data;
         header_err    <= in_valid && hdr_bad;
         // Marker position is block 31 when aligned, or the hunting match itself.
         out_eomb      <= in_valid && (state_next == LOCKED) &&
                          ((state == HUNT) || (blk == LAST_BLK));
         fec_out_valid <= in_valid && (state == LOCKED) && (blk == FEC_VALID_BLK);
         if (in_valid) begin
            hist <= hist_next;
            if (blk <= FEC_LAST_BLK) fec_sr  <= {fec_sr[FEC_WIDTH-3:0], sh};
            if (blk == FEC_LAST_BLK) fec_out <= {fec_sr, sh};
         end
      end
   end

endmodule

// File: tb/tb_jesd204_rx_fec_header_extract.sv
// Directed bench for jesd204_rx_fec_header_extract: false-marker rejection, lock,
// FEC extraction, marker loss, header errors, valid gaps and mid-stream reset.
module tb_jesd204_rx_fec_header_extract;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_header;
   logic [63:0] in_data;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_eomb;
   logic [25:0] fec_out;
   logic        fec_out_valid;
   logic        locked;
   logic        header_err;
   logic        marker_err;

   int n_vec    = 0;
   int n_err    = 0;
   int cyc      = 0;
   int eomb_cyc = 0;
   int fecv_cyc = 0;
   int merr_n   = 0;
   int sent     = 0;

   localparam logic [25:0] F_MIMIC = 26'b10000101010101010101010101;
   localparam logic [25:0] FA = 26'h2AAAAAA;
   localparam logic [25:0] FB = 26'h1555555;
   localparam logic [25:0] FC = 26'h3333333;
   localparam logic [25:0] FD = 26'h2DB6DB6;
   localparam logic [25:0] FE = 26'h36DB6DB;
   localparam logic [25:0] FF = 26'h3FFFFFF;

   jesd204_rx_fec_header_extract dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_header     (in_header),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_eomb      (out_eomb),
      .fec_out       (fec_out),
      .fec_out_valid (fec_out_valid),
      .locked        (locked),
      .header_err    (header_err),
      .marker_err    (marker_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (out_eomb)      eomb_cyc = cyc;
      if (fec_out_valid) fecv_cyc = cyc;
      if (marker_err)    merr_n++;
   endtask

   function automatic logic [1:0] hdr_of(input logic [25:0] fec, input int i);
      if (i < 26)             return fec[25 - i] ? 2'b01 : 2'b10;
      if (i == 26 || i == 31) return 2'b01;
      return 2'b10;
   endfunction

   task automatic send_mb(input logic [25:0] fec, input int first, input int last,
                          input int bad_idx, input logic [1:0] bad_hdr);
      for (int i = first; i <= last; i++) begin
         logic [63:0] d;
         d = {32'(sent), ~32'(sent)};
         sent++;
         in_valid  = 1'b1;
         in_data   = d;
         in_header = (i == bad_idx) ? bad_hdr : hdr_of(fec, i);
         tick();
         chk("out_valid", 64'(out_valid), 64'd1);
         chk("out_data", out_data, d);
      end
      in_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid  = 1'b0;
         in_header = 2'b01;
         tick();
         chk("gap_out_valid", 64'(out_valid), 64'd0);
         chk("gap_eomb", 64'(out_eomb), 64'd0);
         chk("gap_fecv", 64'(fec_out_valid), 64'd0);
         chk("gap_fec_hold", 64'(fec_out), 64'(26'h3EFFFFF));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"}, out_data, 64'd0);
      chk({tag, "_eomb"}, 64'(out_eomb), 64'd0);
      chk({tag, "_fec_out"}, 64'(fec_out), 64'd0);
      chk({tag, "_fecv"}, 64'(fec_out_valid), 64'd0);
      chk({tag, "_locked"}, 64'(locked), 64'd0);
      chk({tag, "_header_err"}, 64'(header_err), 64'd0);
      chk({tag, "_marker_err"}, 64'(marker_err), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_header = 2'b10;
      in_data   = 64'd0;
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // False marker inside FEC bits of MB1, rejected at the next check.
      send_mb(F_MIMIC, 0, 31, -1, 2'b00);
      send_mb(FA, 0, 5, -1, 2'b00);
      chk("mimic_marker_err", 64'(marker_err), 64'd1);
      chk("mimic_merr_count", 64'(merr_n), 64'd1);
      send_mb(FA, 6, 31, -1, 2'b00);
      chk("mb2_locked", 64'(locked), 64'd0);
      send_mb(FB, 0, 31, -1, 2'b00);
      send_mb(FC, 0, 31, -1, 2'b00);
      chk("mb4_locked", 64'(locked), 64'd0);
      chk("mb4_eomb", 64'(out_eomb), 64'd0);
      send_mb(FD, 0, 30, -1, 2'b00);
      chk("mb5_b30_locked", 64'(locked), 64'd0);
      send_mb(FD, 31, 31, -1, 2'b00);
      chk("lock_rise", 64'(locked), 64'd1);
      chk("lock_eomb", 64'(out_eomb), 64'd1);
      chk("lock_merr_count", 64'(merr_n), 64'd1);

      // First extracted FEC word after lock.
      send_mb(FC, 0, 26, -1, 2'b00);
      chk("mb6_fecv", 64'(fec_out_valid), 64'd1);
      chk("mb6_fec", 64'(fec_out), 64'(FC));
      chk("mb6_spacing", 64'(fecv_cyc - eomb_cyc), 64'd27);
      send_mb(FC, 27, 31, -1, 2'b00);
      chk("mb6_eomb", 64'(out_eomb), 64'd1);

      // Single bad marker keeps lock.
      send_mb(FA, 0, 31, 31, 2'b10);
      chk("bad1_marker_err", 64'(marker_err), 64'd1);
      chk("bad1_locked", 64'(locked), 64'd1);
      chk("bad1_header_err", 64'(header_err), 64'd0);
      send_mb(FB, 0, 31, -1, 2'b00);
      chk("good_marker_err", 64'(marker_err), 64'd0);
      chk("good_locked", 64'(locked), 64'd1);

      // Invalid header at block 5 clears FEC bit 20.
      send_mb(FF, 0, 5, 5, 2'b11);
      chk("hdr_err_pulse", 64'(header_err), 64'd1);
      chk("hdr_err_no_merr", 64'(marker_err), 64'd0);
      send_mb(FF, 6, 26, 5, 2'b11);
      chk("hdr_fecv", 64'(fec_out_valid), 64'd1);
      chk("hdr_fec_bit20", 64'(fec_out), 64'(26'h3EFFFFF));
      send_mb(FF, 27, 31, 5, 2'b11);

      // Three-cycle valid gap mid-multiblock.
      send_mb(FE, 0, 10, -1, 2'b00);
      gap(3);
      send_mb(FE, 11, 26, -1, 2'b00);
      chk("gap_fecv", 64'(fec_out_valid), 64'd1);
      chk("gap_fec", 64'(fec_out), 64'(FE));
      chk("gap_spacing", 64'(fecv_cyc - eomb_cyc), 64'd30);
      send_mb(FE, 27, 31, -1, 2'b00);
      chk("gap_eomb", 64'(out_eomb), 64'd1);

      // Two consecutive bad markers drop lock at block 31 of the second.
      send_mb(FA, 0, 31, 31, 2'b10);
      chk("bad2a_locked", 64'(locked), 64'd1);
      send_mb(FB, 0, 30, 31, 2'b11);
      chk("bad2b_b30_locked", 64'(locked), 64'd1);
      send_mb(FB, 31, 31, 31, 2'b11);
      chk("unlock_locked", 64'(locked), 64'd0);
      chk("unlock_eomb", 64'(out_eomb), 64'd0);
      chk("unlock_marker_err", 64'(marker_err), 64'd1);
      chk("unlock_header_err", 64'(header_err), 64'd1);
      chk("unlock_merr_count", 64'(merr_n), 64'd4);

      // Relock after four good markers.
      send_mb(FA, 0, 31, -1, 2'b00);
      send_mb(FB, 0, 31, -1, 2'b00);
      send_mb(FC, 0, 31, -1, 2'b00);
      chk("relock_mb15_locked", 64'(locked), 64'd0);
      send_mb(FD, 0, 31, -1, 2'b00);
      chk("relock_locked", 64'(locked), 64'd1);
      chk("relock_eomb", 64'(out_eomb), 64'd1);

      // Reset while locked, mid multiblock.
      send_mb(FC, 0, 10, -1, 2'b00);
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'hDEAD_BEEF_0123_4567;
      in_header = 2'b11;
      tick();
      chk_all_zero("midrst");
      rst      = 1'b0;
      in_valid = 1'b0;
      send_mb(FA, 0, 31, -1, 2'b00);
      send_mb(FB, 0, 31, -1, 2'b00);
      send_mb(FC, 0, 31, -1, 2'b00);
      chk("rst_relock_mb3_locked", 64'(locked), 64'd0);
      send_mb(FD, 0, 31, -1, 2'b00);
      chk("rst_relock_locked", 64'(locked), 64'd1);
      chk("rst_relock_eomb", 64'(out_eomb), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
